icache_refill_unit: RTL and testbench

Memory-side refill engine directly downstream of `icache_top`. It accepts one line-miss request at a time from the cache's down interface and issues a single burst read to the memory fabric. It assembles the returned beats into a full cache line and hands the line back to the cache with an error flag. Only one miss is outstanding at a time; the cache stalls on `miss_rdy` while a refill is in flight.

---
 rtl/icache_refill_pkg.sv | 22 ++
 rtl/icache_refill_linebuf.sv | 69 ++++++
 rtl/icache_refill_unit.sv | 126 ++++++++++++
 tb/tb_icache_refill_unit.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_refill_pkg.sv
// Shared types and parameter-derived constants for the instruction-cache refill engine.
package icache_refill_pkg;

    localparam int unsigned LEN_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DATA,
        RESP
    } refill_state_e;

    function automatic int unsigned calc_beats(input int unsigned line_bytes,
                                               input int unsigned bus_w);
        return (line_bytes * 8) / bus_w;
    endfunction

    function automatic int unsigned calc_off_w(input int unsigned line_bytes);
        return $clog2(line_bytes);
    endfunction

endpackage

// File: rtl/icache_refill_linebuf.sv
// Beat assembly buffer: saturating slot counter, line register and burst-shape error tracking.
module icache_refill_linebuf #(
    parameter int unsigned BUS_W  = 64,
    parameter int unsigned BEATS  = 8,
    parameter int unsigned LINE_W = 512
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              beat_en,
    input  logic [BUS_W-1:0]  data,
    input  logic              last,
    input  logic              err_in,
    output logic [LINE_W-1:0] line,
    output logic              err
);

    localparam int unsigned     CNT_W    = $clog2(BEATS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BEATS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);

    logic [CNT_W-1:0] cnt;
    logic [BEATS-1:0] slot_we;
    logic             overrun;
    logic             short_burst;

    always_comb begin
        slot_we = '0;
        for (int unsigned k = 0; k < BEATS; k++) begin
            slot_we[k] = beat_en && (cnt == CNT_W'(k));
        end
        overrun     = beat_en && (cnt >= CNT_MAX);
        short_burst = beat_en && last && (cnt != CNT_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (beat_en && (cnt < CNT_MAX)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (clr) begin
            err <= 1'b0;
        end else if (beat_en) begin
            err <= err | err_in | overrun | short_burst;
        end
    end

    // Slots are not cleared between misses; a short burst leaves stale data behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line <= '0;
        end else begin
            for (int unsigned k = 0; k < BEATS; k++) begin
                if (slot_we[k]) begin
                    line[k*BUS_W +: BUS_W] <= data;
                end
            end
        end
    end

endmodule

// File: rtl/icache_refill_unit.sv
// Single-outstanding line refill engine: one burst read per miss, line returned with an error flag.
module icache_refill_unit
    import icache_refill_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned ID_W       = 4,
    parameter int unsigned LINE_BYTES = 64,
    parameter int unsigned BUS_W      = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    miss_vld,
    output logic                    miss_rdy,
    input  logic [ADDR_W-1:0]       miss_addr,
    input  logic [ID_W-1:0]         miss_id,
    output logic                    mem_req_vld,
    input  logic                    mem_req_rdy,
    output logic [ADDR_W-1:0]       mem_req_addr,
    output logic [LEN_W-1:0]        mem_req_len,
    input  logic                    mem_rsp_vld,
    output logic                    mem_rsp_rdy,
    input  logic [BUS_W-1:0]        mem_rsp_data,
    input  logic                    mem_rsp_last,
    input  logic                    mem_rsp_err,
    output logic                    refill_vld,
    input  logic                    refill_rdy,
    output logic [ADDR_W-1:0]       refill_addr,
    output logic [ID_W-1:0]         refill_id,
    output logic [LINE_BYTES*8-1:0] refill_data,
    output logic                    refill_err,
    output logic                    busy
);

    localparam int unsigned      BEATS     = calc_beats(LINE_BYTES, BUS_W);
    localparam int unsigned      OFF_W     = calc_off_w(LINE_BYTES);
    localparam int unsigned      LINE_W    = LINE_BYTES * 8;
    localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << OFF_W;

    refill_state_e     state;
    refill_state_e     next_state;
    logic              out_of_reset;
    logic              accept;
    logic              beat_en;
    logic [ADDR_W-1:0] addr_q;
    logic [ID_W-1:0]   id_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Holds miss_rdy low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_of_reset <= 1'b0;
        end else begin
            out_of_reset <= 1'b1;
        end
    end

    always_comb begin
        next_state  = state;
        miss_rdy    = 1'b0;
        mem_req_vld = 1'b0;
        mem_rsp_rdy = 1'b0;
        refill_vld  = 1'b0;
        busy        = (state != IDLE);
        case (state)
            IDLE: begin
                miss_rdy = out_of_reset;
                if (miss_vld && out_of_reset) next_state = REQ;
            end
            REQ: begin
                mem_req_vld = 1'b1;
                if (mem_req_rdy) next_state = DATA;
            end
            DATA: begin
                mem_rsp_rdy = 1'b1;
                if (mem_rsp_vld && mem_rsp_last) next_state = RESP;
            end
            RESP: begin
                refill_vld = 1'b1;
                if (refill_rdy) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign accept  = miss_vld && miss_rdy;
    assign beat_en = mem_rsp_vld && mem_rsp_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            id_q   <= '0;
        end else if (accept) begin
            addr_q <= miss_addr & LINE_MASK;
            id_q   <= miss_id;
        end
    end

    icache_refill_linebuf #(
        .BUS_W  (BUS_W),
        .BEATS  (BEATS),
        .LINE_W (LINE_W)
    ) u_linebuf (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (accept),
        .beat_en (beat_en),
        .data    (mem_rsp_data),
        .last    (mem_rsp_last),
        .err_in  (mem_rsp_err),
        .line    (refill_data),
        .err     (refill_err)
    );

    assign mem_req_addr = addr_q;
    assign mem_req_len  = LEN_W'(BEATS - 1);
    assign refill_addr  = addr_q;
    assign refill_id    = id_q;

endmodule

// File: tb/tb_icache_refill_unit.sv
// Directed bench for icache_refill_unit with default parameters (8 beats of 64 bits per line).
module tb_icache_refill_unit;

    localparam int unsigned BEATS  = 8;
    localparam int unsigned BUS_W  = 64;
    localparam int unsigned LINE_W = 512;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              miss_vld;
    logic              miss_rdy;
    logic [31:0]       miss_addr;
    logic [3:0]        miss_id;
    logic              mem_req_vld;
    logic              mem_req_rdy;
    logic [31:0]       mem_req_addr;
    logic [7:0]        mem_req_len;
    logic              mem_rsp_vld;
    logic              mem_rsp_rdy;
    logic [63:0]       mem_rsp_data;
    logic              mem_rsp_last;
    logic              mem_rsp_err;
    logic              refill_vld;
    logic              refill_rdy;
    logic [31:0]       refill_addr;
    logic [3:0]        refill_id;
    logic [LINE_W-1:0] refill_data;
    logic              refill_err;
    logic              busy;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc    = 0;
    int unsigned acc_cyc;
    int unsigned prev_acc;
    int          gaps;
    int          prev_gaps;
    logic [LINE_W-1:0] model_line;
    logic [3:0]        sb_id[$];
    logic [31:0]       sb_addr[$];
    logic [3:0]        e_id;
    logic [31:0]       e_addr;
    logic [31:0]       r_addr;
    logic [63:0]       r_base;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    icache_refill_unit #(
        .ADDR_W     (32),
        .ID_W       (4),
        .LINE_BYTES (64),
        .BUS_W      (64)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .miss_vld     (miss_vld),
        .miss_rdy     (miss_rdy),
        .miss_addr    (miss_addr),
        .miss_id      (miss_id),
        .mem_req_vld  (mem_req_vld),
        .mem_req_rdy  (mem_req_rdy),
        .mem_req_addr (mem_req_addr),
        .mem_req_len  (mem_req_len),
        .mem_rsp_vld  (mem_rsp_vld),
        .mem_rsp_rdy  (mem_rsp_rdy),
        .mem_rsp_data (mem_rsp_data),
        .mem_rsp_last (mem_rsp_last),
        .mem_rsp_err  (mem_rsp_err),
        .refill_vld   (refill_vld),
        .refill_rdy   (refill_rdy),
        .refill_addr  (refill_addr),
        .refill_id    (refill_id),
        .refill_data  (refill_data),
        .refill_err   (refill_err),
        .busy         (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_miss_rdy"},    miss_rdy,     '0);
        chk({tag, "_req_vld"},     mem_req_vld,  '0);
        chk({tag, "_rsp_rdy"},     mem_rsp_rdy,  '0);
        chk({tag, "_refill_vld"},  refill_vld,   '0);
        chk({tag, "_refill_err"},  refill_err,   '0);
        chk({tag, "_busy"},        busy,         '0);
        chk({tag, "_refill_data"}, refill_data,  '0);
        chk({tag, "_refill_addr"}, refill_addr,  '0);
        chk({tag, "_refill_id"},   refill_id,    '0);
        chk({tag, "_req_addr"},    mem_req_addr, '0);
    endtask

    task automatic start_miss(input logic [31:0] addr, input logic [3:0] id);
        chk("miss_rdy_idle", miss_rdy, 1'b1);
        miss_vld  = 1'b1;
        miss_addr = addr;
        miss_id   = id;
        acc_cyc   = cyc;
        tick();
        miss_vld  = 1'b0;
        miss_addr = 32'hDEAD_BEEF;
        miss_id   = 4'hF;
        chk("busy_after_accept", busy, 1'b1);
        chk("miss_rdy_after_accept", miss_rdy, 1'b0);
    endtask

    task automatic req_phase(input int stall, input logic [31:0] exp_addr);
        mem_req_rdy = (stall == 0);
        for (int i = 0; i < stall; i++) begin
            chk("req_vld_stall", mem_req_vld, 1'b1);
            chk("req_addr_stall", mem_req_addr, exp_addr);
            chk("req_len_stall", mem_req_len, 8'd7);
            chk("miss_rdy_stall", miss_rdy, 1'b0);
            tick();
        end
        mem_req_rdy = 1'b1;
        chk("req_vld", mem_req_vld, 1'b1);
        chk("req_addr", mem_req_addr, exp_addr);
        chk("req_len", mem_req_len, 8'd7);
        tick();
        chk("req_vld_dropped", mem_req_vld, 1'b0);
    endtask

    task automatic send_beats(input int n, input int last_at, input int err_at,
                              input logic [63:0] base, input int gapmax, output int gap_total);
        gap_total = 0;
        for (int k = 0; k < n; k++) begin
            int g;
            g = (gapmax > 0) ? int'($urandom_range(gapmax)) : 0;
            mem_rsp_vld = 1'b0;
            repeat (g) tick();
            gap_total += g;
            chk("rsp_rdy", mem_rsp_rdy, 1'b1);
            mem_rsp_vld  = 1'b1;
            mem_rsp_data = base + 64'(k);
            mem_rsp_last = (k == last_at);
            mem_rsp_err  = (k == err_at);
            if (k < BEATS) model_line[k*BUS_W +: BUS_W] = base + 64'(k);
            tick();
        end
        mem_rsp_vld  = 1'b0;
        mem_rsp_last = 1'b0;
        mem_rsp_err  = 1'b0;
        mem_rsp_data = '0;
    endtask

    task automatic finish_refill(input string tag, input logic [3:0] id, input logic [31:0] addr,
                                 input logic err, input int hold);
        chk({tag, "_refill_vld"}, refill_vld, 1'b1);
        chk({tag, "_rsp_rdy_off"}, mem_rsp_rdy, 1'b0);
        refill_rdy = 1'b0;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({tag, "_hold_vld"}, refill_vld, 1'b1);
            chk({tag, "_hold_data"}, refill_data, model_line);
            chk({tag, "_hold_addr"}, refill_addr, addr);
            chk({tag, "_hold_miss_rdy"}, miss_rdy, 1'b0);
        end
        chk({tag, "_id"}, refill_id, id);
        chk({tag, "_addr"}, refill_addr, addr);
        chk({tag, "_data"}, refill_data, model_line);
        chk({tag, "_err"}, refill_err, err);
        refill_rdy = 1'b1;
        tick();
        refill_rdy = 1'b0;
        chk({tag, "_vld_after_hs"}, refill_vld, 1'b0);
        chk({tag, "_miss_rdy_after_hs"}, miss_rdy, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        miss_vld     = 1'b0;
        miss_addr    = '0;
        miss_id      = '0;
        mem_req_rdy  = 1'b1;
        mem_rsp_vld  = 1'b0;
        mem_rsp_data = '0;
        mem_rsp_last = 1'b0;
        mem_rsp_err  = 1'b0;
        refill_rdy   = 1'b0;
        model_line   = '0;

        // Reset state
        repeat (2) tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        chk("miss_rdy_before_edge", miss_rdy, 1'b0);
        tick();
        chk("miss_rdy_first_edge", miss_rdy, 1'b1);
        chk("busy_idle", busy, 1'b0);

        // Basic refill with latency check
        start_miss(32'h1234_5678, 4'd3);
        req_phase(0, 32'h1234_5640);
        send_beats(8, 7, -1, 64'h0, 0, gaps);
        chk("basic_latency", cyc - acc_cyc, 32'd10);
        finish_refill("basic", 4'd3, 32'h1234_5640, 1'b0, 0);

        // Backpressure on both request and refill
        start_miss(32'h0000_1FFF, 4'd9);
        req_phase(5, 32'h0000_1FC0);
        send_beats(8, 7, -1, 64'h100, 0, gaps);
        finish_refill("bp", 4'd9, 32'h0000_1FC0, 1'b0, 4);

        // Bus error on beat 4 only
        start_miss(32'hABCD_0040, 4'd1);
        req_phase(0, 32'hABCD_0040);
        send_beats(8, 7, 4, 64'h200, 0, gaps);
        finish_refill("buserr", 4'd1, 32'hABCD_0040, 1'b1, 0);

        // Short burst: slots 6 and 7 keep the previous line's data
        start_miss(32'h0000_00BF, 4'd2);
        req_phase(0, 32'h0000_0080);
        send_beats(6, 5, -1, 64'h300, 0, gaps);
        chk("short_old_slot7", model_line[7*BUS_W +: BUS_W], 64'h207);
        finish_refill("short", 4'd2, 32'h0000_0080, 1'b1, 0);

        // Overrun: ninth beat dropped
        start_miss(32'h8000_0001, 4'd4);
        req_phase(0, 32'h8000_0000);
        send_beats(9, 8, -1, 64'h400, 0, gaps);
        finish_refill("overrun", 4'd4, 32'h8000_0000, 1'b1, 0);

        // Reset mid-DATA after 3 beats
        start_miss(32'h5555_5555, 4'd6);
        req_phase(0, 32'h5555_5540);
        send_beats(3, -1, -1, 64'h500, 0, gaps);
        chk("mid_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        model_line = '0;
        tick();
        rst_n = 1'b1;
        tick();
        start_miss(32'h0F0F_0F3C, 4'd7);
        req_phase(0, 32'h0F0F_0F00);
        send_beats(8, 7, -1, 64'h600, 0, gaps);
        chk("post_reset_latency", cyc - acc_cyc, 32'd10);
        finish_refill("postreset", 4'd7, 32'h0F0F_0F00, 1'b0, 0);

        // Back-to-back misses with random beat gaps against a scoreboard
        prev_gaps = 0;
        prev_acc  = 0;
        for (int i = 0; i < 4; i++) begin
            r_addr = $urandom;
            r_base = {$urandom, $urandom};
            sb_id.push_back(4'(5 + i));
            sb_addr.push_back(r_addr & 32'hFFFF_FFC0);
            start_miss(r_addr, 4'(5 + i));
            if (i > 0) chk("b2b_interval", acc_cyc - prev_acc, 32'(BEATS + 3 + prev_gaps));
            req_phase(0, r_addr & 32'hFFFF_FFC0);
            send_beats(8, 7, -1, r_base, 2, gaps);
            e_id   = sb_id.pop_front();
            e_addr = sb_addr.pop_front();
            chk("b2b_one_outstanding", sb_id.size(), '0);
            finish_refill("b2b", e_id, e_addr, 1'b0, 0);
            prev_gaps = gaps;
            prev_acc  = acc_cyc;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
